// File: rtl/aes_out_buffer.sv
`timescale 1ns/1ps
// aes_out_buffer: sits behind a fixed-latency AES-128 core. A valid pipe
// tracks blocks inside the core, a credit counter throttles acceptance so
// every in-flight block is guaranteed a FIFO slot, and a small FIFO holds
// ciphertexts until the downstream consumer takes them.

// Property checker bound into the buffer; carries no synthesizable logic.
module aes_out_buffer_chk #(
   parameter  int DEPTH = 4,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          overflow_i,
   input  logic [LW-1:0] level_i,
   input  logic [LW-1:0] credits_i
);

   // A push into a full FIFO must never happen while credits are honoured.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !overflow_i);

   // Occupancy and credits both stay inside 0..DEPTH.
   a_level_max: assert property (@(posedge clk) disable iff (rst) level_i <= LW'(DEPTH));
   a_credits_max: assert property (@(posedge clk) disable iff (rst) credits_i <= LW'(DEPTH));

   // Buffered blocks plus remaining credits never exceed the FIFO size.
   a_outstanding: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, level_i} + {1'b0, credits_i}) <= (LW+1)'(DEPTH));

endmodule

module aes_out_buffer #(
   parameter  int LATENCY = 11,
   parameter  int DEPTH   = 4,
   localparam int AW      = $clog2(DEPTH),
   localparam int LW      = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  core_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_data,
   output logic          drop_err,
   output logic [LW-1:0] level
);

   logic [LATENCY-1:0] vpipe_q, vpipe_d;
   logic [LW-1:0]      credits_q, credits_d;
   logic [LW-1:0]      level_q, level_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic               drop_err_q, drop_err_d;
   logic [127:0]       mem_q [DEPTH];

   logic accept_s, pop_s, push_s, full_s, wr_en_s, overflow_s;

   // Handshake decode; in_ready looks only at the registered credit count.
   always_comb begin
      in_ready   = (credits_q != LW'(0));
      out_valid  = (level_q != LW'(0));
      accept_s   = in_valid & in_ready;
      pop_s      = out_valid & out_ready;
      push_s     = vpipe_q[LATENCY-1];
      full_s     = (level_q == LW'(DEPTH));
      // A pop in the same cycle frees the head slot, so a full FIFO can still take the write.
      wr_en_s    = push_s & (~full_s | pop_s);
      overflow_s = push_s & full_s & ~pop_s;
   end

   // Next-state logic for the valid pipe, credits, FIFO pointers and error flag.
   always_comb begin
      vpipe_d    = vpipe_q << 1'b1;
      vpipe_d[0] = accept_s;

      case ({accept_s, pop_s})
         2'b10:   credits_d = credits_q - LW'(1);
         2'b01:   credits_d = credits_q + LW'(1);
         default: credits_d = credits_q;
      endcase

      case ({wr_en_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
      if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      drop_err_d = drop_err_q | (in_valid & ~in_ready);
   end

   // Control state with asynchronous reset; in-flight and buffered blocks are discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe_q    <= '0;
         credits_q  <= LW'(DEPTH);
         level_q    <= LW'(0);
         wr_ptr_q   <= AW'(0);
         rd_ptr_q   <= AW'(0);
         drop_err_q <= 1'b0;
      end else begin
         vpipe_q    <= vpipe_d;
         credits_q  <= credits_d;
         level_q    <= level_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         drop_err_q <= drop_err_d;
      end
   end

   // Ciphertext storage; contents are meaningless while the FIFO is empty, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= core_out;
      end
   end

   assign out_data = mem_q[rd_ptr_q];
   assign level    = level_q;
   assign drop_err = drop_err_q;

   aes_out_buffer_chk #(.DEPTH(DEPTH)) u_chk (
      .clk        (clk),
      .rst        (rst),
      .overflow_i (overflow_s),
      .level_i    (level_q),
      .credits_i  (credits_q)
   );

endmodule

// File: tb/tb_aes_out_buffer.sv
`timescale 1ns/1ps
// Bench for aes_out_buffer. Instance u_dut uses the default configuration;
// u_wide has 16 entries, enough credits to cover the 12-cycle round trip,
// and carries the streaming and mid-operation reset scenarios.
// The core is emulated as an 11-stage delay line: the value placed on
// *_in_ct with an accepted block is the ciphertext the core delivers later.
// For the single-block case that is the FIPS-197 result for
// key 000102..0f / pt 00112233..eeff.
module tb_aes_out_buffer;

   localparam int L  = 11;
   localparam int D  = 4;
   localparam int DW = 16;
   localparam logic [127:0] KNOWN_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] JUNK     = 128'hdeadbeef_0badf00d_55aa55aa_12345678;

   logic         clk = 1'b0;
   logic         rst;

   logic         in_valid, in_ready, out_valid, out_ready, drop_err;
   logic [127:0] in_ct, core_out, out_data;
   logic [2:0]   level;

   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_drop_err;
   logic [127:0] b_in_ct, b_core_out, b_out_data;
   logic [4:0]   b_level;

   logic [127:0] core_pipe   [L];
   logic [127:0] b_core_pipe [L];
   logic [127:0] sb_q [$];
   logic [127:0] sb_b [$];

   int checks = 0, errors = 0, cyc = 0;
   int acc_cnt = 0, pop_cnt = 0, b_pop_cnt = 0, b_last_pop = 0, b_gaps = 0;

   always #5 clk = ~clk;

   aes_out_buffer #(.LATENCY(L), .DEPTH(D)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .core_out(core_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .drop_err(drop_err), .level(level)
   );

   aes_out_buffer #(.LATENCY(L), .DEPTH(DW)) u_wide (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .core_out(b_core_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .drop_err(b_drop_err), .level(b_level)
   );

   assign core_out   = core_pipe[L-1];
   assign b_core_out = b_core_pipe[L-1];

   // Emulated core pipelines and cycle counter.
   always @(posedge clk) begin
      for (int i = L-1; i > 0; i--) begin
         core_pipe[i]   <= core_pipe[i-1];
         b_core_pipe[i] <= b_core_pipe[i-1];
      end
      core_pipe[0]   <= in_ct;
      b_core_pipe[0] <= b_in_ct;
      cyc            <= cyc + 1;
   end

   // Scoreboard feed: every accepted block's ciphertext is expected later, in order.
   always @(posedge clk) begin
      if (!rst && in_valid && in_ready) begin
         sb_q.push_back(in_ct);
         acc_cnt++;
      end
      if (!rst && b_in_valid && b_in_ready) begin
         sb_b.push_back(b_in_ct);
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor for u_dut: compare every popped block against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         pop_cnt++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_out: actual %0h required no output", out_data);
         end else begin
            chk("a_out_data", out_data, sb_q.pop_front());
         end
      end
   end

   // Monitor for u_wide, also noting gaps between consecutive outputs.
   always @(negedge clk) begin
      if (!rst && b_out_valid && b_out_ready) begin
         if (b_pop_cnt > 0 && cyc != b_last_pop + 1) b_gaps++;
         b_last_pop = cyc;
         b_pop_cnt++;
         if (sb_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_out: actual %0h required no output", b_out_data);
         end else begin
            chk("b_out_data", b_out_data, sb_b.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int  k, base, pc, max_lvl;
      bit  found;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_ct = JUNK;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_ct = JUNK;
      max_lvl = 0;

      // reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_level", level, 3'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_drop_err", drop_err, 1'b0);
      chk("rst_b_in_ready", b_in_ready, 1'b1);
      tick(); tick(); rst = 1'b0;
      tick();

      // single block with known ciphertext, out_ready high
      in_valid = 1'b1; in_ct = KNOWN_CT; out_ready = 1'b1;
      k = 0; found = 1'b0;
      for (int n = 1; n <= 30 && !found; n++) begin
         tick();
         if (n == 1) begin in_valid = 1'b0; in_ct = JUNK; end
         @(negedge clk);
         if (out_valid) begin found = 1'b1; k = n; end
      end
      chk("single_latency", k, 12);
      tick(); @(negedge clk);
      chk("single_level_back_0", level, 3'd0);
      chk("single_out_valid_0", out_valid, 1'b0);
      chk("single_sb_empty", sb_q.size(), 0);
      chk("single_drop_err_0", drop_err, 1'b0);

      // back-pressure: in_valid held 8 cycles with out_ready low
      out_ready = 1'b0; base = acc_cnt;
      for (int i = 1; i <= 16; i++) begin
         tick();
         in_valid = (i <= 8);
         in_ct = (i <= 8) ? {32'hB0B0B0B0, 96'(i)} : JUNK;
         @(negedge clk);
         if (i == 4)  chk("bp_in_ready_c4", in_ready, 1'b1);
         if (i == 5)  chk("bp_in_ready_c5", in_ready, 1'b0);
         if (i == 15) chk("bp_level_c15", level, 3'd3);
         if (i == 16) chk("bp_level_c16", level, 3'd4);
      end
      chk("bp_accepts", acc_cnt - base, 4);
      chk("bp_drop_err", drop_err, 1'b1);
      tick(); out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_before_pop", in_ready, 1'b0);
      tick(); @(negedge clk);
      chk("bp_in_ready_after_pop", in_ready, 1'b1);
      chk("bp_level_after_pop", level, 3'd3);
      for (int n = 0; n < 20 && level != 3'd0; n++) begin tick(); @(negedge clk); end
      chk("bp_level_drained", level, 3'd0);
      chk("bp_sb_empty", sb_q.size(), 0);
      chk("bp_drop_err_sticky", drop_err, 1'b1);

      // continuous offers with random out_ready
      for (int i = 0; i < 200; i++) begin
         tick();
         in_valid = 1'b1; in_ct = {32'hC0C0C0C0, 96'(i)};
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      tick(); in_valid = 1'b0; in_ct = JUNK; out_ready = 1'b1;
      for (int n = 0; n < 25; n++) begin tick(); end
      @(negedge clk);
      chk("rt_max_level_le_depth", (max_lvl <= D), 1'b1);
      chk("rt_sb_empty", sb_q.size(), 0);
      chk("rt_accepts_eq_pops", acc_cnt, pop_cnt);

      // streaming 100 blocks into the wide instance
      b_out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         b_in_valid = 1'b1; b_in_ct = {32'hD00DD00D, 96'(i)};
         @(negedge clk);
         chk("stream_in_ready", b_in_ready, 1'b1);
      end
      tick(); b_in_valid = 1'b0; b_in_ct = JUNK;
      for (int n = 0; n < 40 && b_pop_cnt < 100; n++) begin tick(); @(negedge clk); end
      chk("stream_pops", b_pop_cnt, 100);
      chk("stream_gaps", b_gaps, 0);
      chk("stream_sb_empty", sb_b.size(), 0);
      chk("stream_drop_err", b_drop_err, 1'b0);

      // reset with 2 blocks buffered and 3 in flight
      b_out_ready = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         tick();
         b_in_valid = (i == 1 || i == 2 || i >= 11);
         b_in_ct = b_in_valid ? {32'hE0E0E0E0, 96'(i)} : JUNK;
      end
      tick(); b_in_valid = 1'b0; b_in_ct = JUNK;
      @(negedge clk);
      chk("mid_level_before_rst", b_level, 5'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", b_out_valid, 1'b0);
      chk("mid_rst_level", b_level, 5'd0);
      chk("mid_rst_in_ready", b_in_ready, 1'b1);
      chk("mid_rst_a_drop_err", drop_err, 1'b0);
      sb_q.delete(); sb_b.delete();
      tick(); tick(); rst = 1'b0;
      b_out_ready = 1'b1; pc = b_pop_cnt;
      for (int n = 0; n < 20; n++) begin tick(); @(negedge clk); end
      chk("mid_no_stale_out", b_pop_cnt - pc, 0);

      // first block after reset behaves as from power-up
      tick();
      b_in_valid = 1'b1; b_in_ct = KNOWN_CT;
      k = 0; found = 1'b0;
      for (int n = 1; n <= 30 && !found; n++) begin
         tick();
         if (n == 1) begin b_in_valid = 1'b0; b_in_ct = JUNK; end
         @(negedge clk);
         if (b_out_valid) begin found = 1'b1; k = n; end
      end
      chk("post_rst_latency", k, 12);
      tick(); @(negedge clk);
      chk("post_rst_sb_empty", sb_b.size(), 0);
      chk("post_rst_level", b_level, 5'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_out_buffer.md
AES_OUT_BUFFER -- requirements
Module: aes_out_buffer

Interface
REQ-001 Parameter LATENCY, default 11: cycles from an accepted input (state/key presented to the AES-128 core) to the matching ciphertext on the core output.
REQ-002 Parameter DEPTH, default 4: ciphertext FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  upstream offers a block to the core this cycle.
REQ-006 in_ready  output  1  block accepts; the core's state/key is sampled only when in_valid & in_ready.
REQ-007 core_out  input  128  AES-128 core ciphertext output.
REQ-008 out_valid  output  1  out_data holds a buffered ciphertext.
REQ-009 out_ready  input  1  downstream consumer accepts out_data.
REQ-010 out_data  output  128  FIFO head ciphertext.
REQ-011 drop_err  output  1  sticky flag: in_valid seen while in_ready low.
REQ-012 level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-013 accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-014 A valid pipe of LATENCY flops shall shift every cycle with stage 0 loaded by accept; bubbles propagate as 0.
REQ-015 When the pipe tail is 1, core_out shall be written into the FIFO that same cycle (push).
REQ-016 Credit counter, reset value DEPTH: -1 on accept only, +1 on pop only, unchanged when both or neither occur.
REQ-017 in_ready = (credits != 0), combinational from registered credits; no dependency on in_valid.
REQ-018 Credits guarantee push never hits a full FIFO; the FIFO shall still assert an internal overflow check and leave contents unchanged if one occurs.
REQ-019 out_valid = (level != 0); out_data = FIFO head, registered storage, stable while out_valid & !out_ready.
REQ-020 Push and pop in the same cycle: level unchanged, order preserved; this holds at level 0 (the push is visible next cycle, no fall-through) and at level DEPTH.
REQ-021 Read and write pointers wrap modulo DEPTH; level counts 0..DEPTH inclusive.
REQ-022 Ciphertexts shall leave in acceptance order, each exactly once, none lost or duplicated.
REQ-023 Minimum latency accept-to-out_valid = LATENCY+1 cycles.
REQ-024 Throughput: with out_ready held high, one accept per cycle is sustained indefinitely.
REQ-025 drop_err sets on in_valid & !in_ready, stays set until rst.

Reset
REQ-026 rst asserted: valid pipe cleared, FIFO pointers and level = 0, credits = DEPTH, drop_err = 0, out_valid = 0, in_ready = 1, all immediately (asynchronous).
REQ-027 FIFO data storage is not reset; out_data is don't-care while out_valid = 0.
REQ-028 Reset mid-operation discards all in-flight and buffered blocks; the first accept after deassertion behaves as from power-up.
REQ-029 rst deasserts synchronously to clk externally; no accept occurs in the deassertion cycle.

Verification
REQ-030 Single block: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff through the core, out_ready=1 -> out_valid after 12 cycles, out_data 69c4e0d86a7b0430d8cdb78070b4c55a, level returns to 0.
REQ-031 Back-pressure: out_ready=0, in_valid held high 8 cycles -> exactly 4 accepts, in_ready low from the 5th cycle, level reaches 4 after 15 cycles, drop_err=1; then out_ready=1 -> 4 blocks in order, in_ready high after the first pop.
REQ-032 Streaming: 100 consecutive blocks with a counter pattern, out_ready=1 -> in_ready never drops, outputs in order, one per cycle.
REQ-033 Simultaneous push/pop at level 4 with random out_ready toggling -> level never exceeds 4, no overflow, scoreboard matches.
REQ-034 rst pulse while 3 blocks in flight and 2 buffered -> out_valid=0, level=0, in_ready=1 in the same cycle; no stale block is emitted afterwards.
